// File: rtl/wb_regfile_if.sv
// Writeback-stage bus: the MEM/WB pipeline fields, decode read ports, PC redirect and debug count.
// The master drives the pipeline fields and read addresses, and the slave (wb_regfile) drives the results.
interface wb_regfile_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
);
    // There is no valid/ready handshake. The MEM/WB register presents one instruction every cycle.
    // RegWriteW and PCSrcW qualify it, and the other W fields are don't-care when both are low.
    logic [WIDTH-1:0] ReadDataW;
    logic [WIDTH-1:0] ALUOutW;
    logic [3:0]       WA3W;
    logic             MemtoRegW;
    logic             PCSrcW;
    logic             RegWriteW;
    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [WIDTH-1:0] PCPlus8D;
    logic [WIDTH-1:0] RD1D;
    logic [WIDTH-1:0] RD2D;
    logic [WIDTH-1:0] ResultW;
    logic             PCLoadW;
    logic [WIDTH-1:0] PCTargetW;
    logic [CNT_W-1:0] WbCount;

    modport master (
        output ReadDataW, ALUOutW, WA3W, MemtoRegW, PCSrcW, RegWriteW,
        output RA1D, RA2D, PCPlus8D,
        input  RD1D, RD2D, ResultW, PCLoadW, PCTargetW, WbCount
    );

    modport slave (
        input  ReadDataW, ALUOutW, WA3W, MemtoRegW, PCSrcW, RegWriteW,
        input  RA1D, RA2D, PCPlus8D,
        output RD1D, RD2D, ResultW, PCLoadW, PCTargetW, WbCount
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback register file: commits results to R0-R14, redirects the PC on R15 writes, and serves two decode read ports.
// Optional macro WB_BYPASS_EN adds a write-through bypass from the writeback result to the read ports.
module wb_regfile #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input logic         clk,
    input logic         reset_n,
    wb_regfile_if.slave bus
);
    // Entry 15 is never written; R15 reads are served from PCPlus8D.
    logic [WIDTH-1:0] regs [0:15];
    logic [WIDTH-1:0] result;
    logic             pc_load;
    logic [WIDTH-1:0] pc_target;
    logic [CNT_W-1:0] wb_count;
    logic             reg_we;

    always_comb begin
        result = bus.MemtoRegW ? bus.ReadDataW : bus.ALUOutW;
        reg_we = bus.RegWriteW && (bus.WA3W != 4'd15);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            wb_count  <= '0;
        end else begin
            if (reg_we) regs[bus.WA3W] <= result;
            pc_load <= bus.PCSrcW;
            if (bus.PCSrcW) pc_target <= result;
            if (bus.RegWriteW || bus.PCSrcW) wb_count <= wb_count + CNT_W'(1);
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [3:0] addr);
        logic [WIDTH-1:0] data;
        data = regs[addr];
        if (addr == 4'd15) data = bus.PCPlus8D;
`ifdef WB_BYPASS_EN
        else if (reg_we && (addr == bus.WA3W)) data = result;
`else
`endif
        return data;
    endfunction

    always_comb begin
        bus.RD1D      = read_port(bus.RA1D);
        bus.RD2D      = read_port(bus.RA2D);
        bus.ResultW   = result;
        bus.PCLoadW   = pc_load;
        bus.PCTargetW = pc_target;
        bus.WbCount   = wb_count;
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against a behavioural register-file model.
module tb_wb_regfile;
  localparam int W  = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_if #(.WIDTH(W), .CNT_W(CW)) bus ();
  wb_regfile #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // Reference model state
  logic [W-1:0] m_regs [0:14];
  logic         m_pc_load;
  int unsigned  m_cnt;
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_pc_load = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] model_read(input logic [3:0] a, input logic rw,
                                               input logic [3:0] wa, input logic [W-1:0] res,
                                               input logic [W-1:0] pc8);
    if (a == 4'd15) return pc8;
`ifdef WB_BYPASS_EN
    if (rw && wa != 4'd15 && a == wa) return res;
`endif
    return m_regs[a];
  endfunction

  task automatic step(input logic [W-1:0] rd, input logic [W-1:0] alu, input logic [3:0] wa,
                      input logic mtr, input logic pcs, input logic rw,
                      input logic [3:0] ra1, input logic [3:0] ra2, input logic [W-1:0] pc8);
    logic [W-1:0] res;
    @(negedge clk);
    bus.ReadDataW = rd;  bus.ALUOutW = alu; bus.WA3W = wa;  bus.MemtoRegW = mtr;
    bus.PCSrcW = pcs;    bus.RegWriteW = rw; bus.RA1D = ra1; bus.RA2D = ra2; bus.PCPlus8D = pc8;
    #1;
    res = mtr ? rd : alu;
    check_val("result", bus.ResultW, res);
    check_val("rd1", bus.RD1D, model_read(ra1, rw, wa, res, pc8));
    check_val("rd2", bus.RD2D, model_read(ra2, rw, wa, res, pc8));
    check_val("pc_load", W'(bus.PCLoadW), W'(m_pc_load));
    check_val("wb_count", W'(bus.WbCount), W'(m_cnt % 16));
    if (bus.PCLoadW) begin
      if (exp_q.size() == 0) check_val("pc_pulse_unexpected", 1, 0);
      else check_val("pc_target", bus.PCTargetW, exp_q.pop_front());
    end
    @(posedge clk);
    if (reset_n) begin
      if (rw && wa != 4'd15) m_regs[wa] = res;
      m_pc_load = pcs;
      if (pcs) exp_q.push_back(res);
      if (rw || pcs) m_cnt++;
    end
  endtask

  task automatic idle_read(input logic [3:0] ra1, input logic [3:0] ra2, input logic [W-1:0] pc8);
    step('0, '0, 4'd0, 1'b0, 1'b0, 1'b0, ra1, ra2, pc8);
  endtask

  initial begin
    logic [3:0] wa;
    bus.ReadDataW = '0; bus.ALUOutW = '0; bus.WA3W = '0; bus.MemtoRegW = 1'b0;
    bus.PCSrcW = 1'b0;  bus.RegWriteW = 1'b0; bus.RA1D = '0; bus.RA2D = '0; bus.PCPlus8D = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    idle_read(4'd3, 4'd0, 32'h0000_0008);
    check_val("reset_count", W'(bus.WbCount), 0);

    // ALU write then read
    step(32'h0, 32'h0000_1234, 4'd5, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 32'h8);
    idle_read(4'd5, 4'd5, 32'h8);
    check_val("r5_direct", bus.RD1D, 32'h0000_1234);
    check_val("count_one", W'(bus.WbCount), 1);

    // Load select into R14
    step(32'hDEAD_BEEF, 32'h1, 4'd14, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 32'h8);
    idle_read(4'd14, 4'd0, 32'h8);
    check_val("r14_direct", bus.RD1D, 32'hDEAD_BEEF);

    // R15 redirect and R15 read
    step(32'h0, 32'h0000_0100, 4'd15, 1'b0, 1'b1, 1'b1, 4'd0, 4'd15, 32'h48);
    idle_read(4'd5, 4'd15, 32'h0000_0048);
    check_val("redirect_target", bus.PCTargetW, 32'h100);
    check_val("r15_read", bus.RD2D, 32'h48);
    idle_read(4'd14, 4'd5, 32'h48);

    // Same-cycle write/read on R7, then back-to-back redirects
    step(32'h0, 32'hA5A5_A5A5, 4'd7, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 32'h8);
    idle_read(4'd7, 4'd7, 32'h8);
    step(32'h0, 32'h200, 4'd15, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 32'h8);
    step(32'h0, 32'h300, 4'd2, 1'b0, 1'b1, 1'b1, 4'd2, 4'd0, 32'h8);
    idle_read(4'd2, 4'd7, 32'h8);

    // Counter wrap: 16 consecutive writes
    for (int i = 0; i < 16; i++)
      step($urandom, $urandom, 4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      wa = 4'($urandom_range(0, 15));
      step($urandom, $urandom, wa, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15)), $urandom);
    end

    // Asynchronous reset mid-cycle with a write and redirect presented
    @(negedge clk);
    bus.RegWriteW = 1'b1; bus.PCSrcW = 1'b1; bus.WA3W = 4'd3; bus.ALUOutW = 32'hFFFF_0000;
    bus.MemtoRegW = 1'b0; bus.RA1D = 4'd3;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_pc_load", W'(bus.PCLoadW), 0);
    check_val("rst_pc_target", bus.PCTargetW, 0);
    check_val("rst_count", W'(bus.WbCount), 0);
    @(posedge clk);
    @(negedge clk);
    bus.RegWriteW = 1'b0; bus.PCSrcW = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i += 2) idle_read(4'(i), 4'(i + 1), 32'h8);

    for (int i = 0; i < 200; i++) begin
      wa = 4'($urandom_range(0, 15));
      step($urandom, $urandom, wa, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
